jtvigil_pcmch: RTL and testbench

Multi-channel PCM sample playback controller for the sound subsystem. It is the parametrised successor of the single-counter PCM address logic driven by the sound Z80. It provides NCH independent channels, each with a CPU-loaded start address and either CPU-stepped or self-timed playback. A round-robin fetch engine shares one ROM port, and per-channel sample bytes are presented to the mixer.

---
 rtl/jtvigil_pcmch.sv | 217 +++++++++++++++++++++
 tb/tb_jtvigil_pcmch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtvigil_pcmch.sv
// jtvigil_pcmch: NCH-channel PCM playback with a shared round-robin ROM fetch port.
// Define PCM_LOOP_EN to add per-channel loop offsets (regs 6/7, ctrl bit2).
`default_nettype none

module jtvigil_pcmch #(
  parameter int NCH  = 2,
  parameter int AW   = 16,
  parameter int DIVW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [4:0]       cpu_addr,
  input  logic [7:0]       cpu_din,
  output logic [7:0]       cpu_dout,
  output logic             pcm_cs,
  output logic [AW-1:0]    pcm_addr,
  input  logic [7:0]       pcm_data,
  input  logic             pcm_ok,
  output logic [8*NCH-1:0] snd,
  output logic [NCH-1:0]   busy
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT} st_t;

  st_t             st;
  logic [AW-1:0]   addr   [NCH];
  logic [DIVW-1:0] rate   [NCH];
  logic [DIVW-1:0] div    [NCH];
  logic [7:0]      sample [NCH];
  logic [NCH-1:0]  auto_m, busy_r, pend;
  logic [CW-1:0]   cur, last, sel;
  logic            found, wr_q;
`ifdef PCM_LOOP_EN
  logic [AW-1:0]   start_a  [NCH];
  logic [15:0]     loop_off [NCH];
  logic [NCH-1:0]  loop_m;
`endif

  logic [1:0]    a_ch;
  logic [2:0]    a_reg;
  logic [CW-1:0] a_idx;
  logic          ch_ok, wr_ok;
  logic [AW-1:0] cur_a, ld_lo, ld_hi, ld_bank;
  logic [7:0]    rd_data;

  assign a_ch  = cpu_addr[4:3];
  assign a_reg = cpu_addr[2:0];
  assign a_idx = cpu_addr[3 +: CW];
  assign ch_ok = int'(a_ch) < NCH;
  assign wr_ok = cpu_wr & ~wr_q & ch_ok;
  assign cur_a = addr[a_idx];
  assign ld_lo = {cur_a[AW-1:8], cpu_din};

  generate
    if (AW > 16) begin : g_bank
      assign ld_hi   = {cur_a[AW-1:16], cpu_din, cur_a[7:0]};
      assign ld_bank = {cpu_din[AW-17:0], cur_a[15:0]};
    end else begin : g_nobank
      assign ld_hi   = {cpu_din, cur_a[7:0]};
      assign ld_bank = cur_a;
    end
  endgenerate

  always_comb begin
    rd_data = 8'hFF;
    if (ch_ok) begin
      case (a_reg)
        3'd0:    rd_data = sample[a_idx];
        3'd3:    rd_data = {6'b0, busy_r[a_idx], auto_m[a_idx]};
        default: rd_data = 8'hFF;
      endcase
    end
  end

  // Round-robin scan starting just after the last channel served
  always_comb begin
    found = 1'b0;
    sel   = last;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && pend[(int'(last) + i) % NCH]) begin
        found = 1'b1;
        sel   = CW'((int'(last) + i) % NCH);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      pcm_cs   <= 1'b0;
      pcm_addr <= '0;
      cpu_dout <= 8'hFF;
      wr_q     <= 1'b0;
      cur      <= '0;
      last     <= CW'(NCH - 1);
      auto_m   <= '0;
      busy_r   <= '0;
      pend     <= '0;
      for (int c = 0; c < NCH; c++) begin
        addr[c]   <= '0;
        rate[c]   <= '0;
        div[c]    <= '0;
        sample[c] <= 8'h80;
      end
`ifdef PCM_LOOP_EN
      loop_m <= '0;
      for (int c = 0; c < NCH; c++) begin
        start_a[c]  <= '0;
        loop_off[c] <= '0;
      end
`endif
    end else begin
      wr_q <= cpu_wr;
      if (cpu_rd) cpu_dout <= rd_data;

      // Grant clears pending first so a same-cycle advance or load re-arms it
      if (st == S_IDLE && found) pend[sel] <= 1'b0;

      for (int c = 0; c < NCH; c++) begin
        if (cen && busy_r[c]) begin
          if (div[c] == rate[c]) begin
            div[c]  <= '0;
            addr[c] <= addr[c] + 1'b1;
            pend[c] <= 1'b1;
          end else begin
            div[c] <= div[c] + 1'b1;
          end
        end
      end

      case (st)
        S_IDLE: if (found) begin
          cur      <= sel;
          last     <= sel;
          pcm_addr <= addr[sel];
          pcm_cs   <= 1'b1;
          st       <= S_SETUP;
        end
        S_SETUP: st <= S_WAIT;
        S_WAIT: if (pcm_ok) begin
          pcm_cs <= 1'b0;
          st     <= S_IDLE;
          // A pending flag re-armed during service marks the data stale
          if (!pend[cur]) begin
            if (auto_m[cur] && pcm_data == 8'hFF) begin
              sample[cur] <= 8'h80;
              div[cur]    <= '0;
`ifdef PCM_LOOP_EN
              if (loop_m[cur] && busy_r[cur]) begin
                addr[cur] <= start_a[cur] + AW'(loop_off[cur]);
                pend[cur] <= 1'b1;
              end else begin
                addr[cur]   <= pcm_addr;
                pend[cur]   <= 1'b0;
                busy_r[cur] <= 1'b0;
              end
`else
              addr[cur]   <= pcm_addr;
              pend[cur]   <= 1'b0;
              busy_r[cur] <= 1'b0;
`endif
            end else begin
              sample[cur] <= pcm_data;
            end
          end
        end
        default: st <= S_IDLE;
      endcase

      // CPU writes come last so they win over the automatic advance
      if (wr_ok) begin
        case (a_reg)
          3'd0: begin addr[a_idx] <= ld_lo;   pend[a_idx] <= 1'b1; end
          3'd1: begin addr[a_idx] <= ld_hi;   pend[a_idx] <= 1'b1; end
          3'd5: begin addr[a_idx] <= ld_bank; pend[a_idx] <= 1'b1; end
          3'd2: if (!auto_m[a_idx]) begin
            addr[a_idx] <= cur_a + 1'b1;
            pend[a_idx] <= 1'b1;
          end
          3'd3: begin
            auto_m[a_idx] <= cpu_din[0];
            busy_r[a_idx] <= cpu_din[0] & cpu_din[1];
`ifdef PCM_LOOP_EN
            loop_m[a_idx] <= cpu_din[2];
            if (cpu_din[0] && cpu_din[1]) start_a[a_idx] <= cur_a;
`endif
            if (cpu_din[0] && cpu_din[1]) begin
              div[a_idx]  <= '0;
              pend[a_idx] <= 1'b1;
            end
          end
          3'd4: rate[a_idx] <= DIVW'(cpu_din);
`ifdef PCM_LOOP_EN
          3'd6: loop_off[a_idx][7:0]  <= cpu_din;
          3'd7: loop_off[a_idx][15:8] <= cpu_din;
`endif
          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_snd
      assign snd[8*g +: 8] = sample[g];
    end
  endgenerate

  assign busy = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_jtvigil_pcmch.sv
// Directed self-checking bench for jtvigil_pcmch (NCH=2, AW=16) with a latency-configurable ROM model.
`default_nettype none

module tb_jtvigil_pcmch;
  logic        clk = 1'b0, rst = 1'b0, cen = 1'b0;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [7:0]  cpu_din = '0, cpu_dout;
  logic        pcm_cs, pcm_ok = 1'b0;
  logic [15:0] pcm_addr;
  logic [7:0]  pcm_data = '0;
  logic [15:0] snd;
  logic [1:0]  busy;

  int errors = 0, checks = 0;
  int lat = 2, cnt = 0, cyc = 0;
  logic cen_all = 1'b1, cs_prev = 1'b0;
  logic [15:0] gq[$];
  int          gt[$];

  jtvigil_pcmch dut (
    .clk(clk), .rst(rst), .cen(cen),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .snd(snd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) cen = cen_all ? 1'b1 : ~cen;

  function automatic logic [7:0] rom(input logic [15:0] a);
    if (a >= 16'h2000) return 8'h55;
    case (a)
      16'h0100: return 8'h10;
      16'h0101: return 8'h20;
      16'h0102: return 8'h30;
      16'h0103: return 8'hFF;
      default:  return a[7:0];
    endcase
  endfunction

  // ROM answers once pcm_cs has been high for lat negedges
  always @(negedge clk) begin
    if (pcm_cs) begin
      cnt++;
      if (cnt >= lat) begin
        pcm_ok   = 1'b1;
        pcm_data = rom(pcm_addr);
      end
    end else begin
      cnt    = 0;
      pcm_ok = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (pcm_cs && !cs_prev) begin
      gq.push_back(pcm_addr);
      gt.push_back(cyc);
    end
    cs_prev = pcm_cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d, input int hold);
    cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    repeat (hold) @(negedge clk);
    cpu_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [4:0] a);
    cpu_addr = a; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    settle(1);
  endtask

  task automatic wait_grants(input int n, input string tag);
    for (int i = 0; i < 300 && gq.size() < n; i++) @(negedge clk);
    chk(tag, 32'(gq.size() >= n), 32'd1);
  endtask

  initial begin
    logic [7:0] sq[$];
    int viol;
    logic saw40;

    @(negedge clk);
    do_reset();
    chk("reset_snd", snd, 16'h8080);
    chk("reset_busy", busy, 2'b00);
    chk("reset_cs", pcm_cs, 1'b0);
    chk("reset_dout", cpu_dout, 8'hFF);
    chk("reset_addr", pcm_addr, 16'h0000);

    // Manual stepping on ch0
    cpu_write(5'd1, 8'h12, 1); settle(8);
    cpu_write(5'd0, 8'hFF, 1); settle(8);
    chk("man_load_addr", pcm_addr, 16'h12FF);
    chk("man_load_snd", snd[7:0], 8'hFF);
    cpu_write(5'd2, 8'h00, 1); settle(8);
    chk("man_step1_addr", pcm_addr, 16'h1300);
    chk("man_step1_snd", snd[7:0], 8'h00);
    cpu_write(5'd2, 8'h5A, 1); settle(8);
    chk("man_step2_addr", pcm_addr, 16'h1301);
    chk("man_step2_snd", snd[7:0], 8'h01);
    cpu_write(5'd2, 8'hA5, 1); settle(8);
    chk("man_step3_addr", pcm_addr, 16'h1302);
    chk("man_step3_snd", snd[7:0], 8'h02);
    cpu_write(5'd2, 8'h00, 10); settle(8);
    chk("man_hold_addr", pcm_addr, 16'h1303);
    chk("man_hold_snd", snd[7:0], 8'h03);

    cpu_read(5'd0);  chk("rd_sample", cpu_dout, 8'h03);
    cpu_read(5'd3);  chk("rd_ctrl", cpu_dout, 8'h00);
    cpu_read(5'd4);  chk("rd_rate", cpu_dout, 8'hFF);
    cpu_read(5'd16); chk("rd_badch", cpu_dout, 8'hFF);

    // Auto playback on ch1 with rate 3 and cen every other clk
    cpu_write(5'd9, 8'h01, 1);
    cpu_write(5'd8, 8'h00, 1); settle(8);
    cpu_write(5'd12, 8'h03, 1);
    cen_all = 1'b0;
    settle(2);
    gq.delete(); gt.delete();
    sq.delete(); sq.push_back(snd[15:8]);
    cpu_write(5'd11, 8'h03, 1);
    chk("auto_busy_on", busy[1], 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (snd[15:8] != sq[$]) begin
        sq.push_back(snd[15:8]);
        if (snd[15:8] == 8'h80) chk("auto_busy_fall_at_marker", busy[1], 1'b0);
      end
    end
    chk("auto_nvals", sq.size(), 4);
    if (sq.size() == 4) begin
      chk("auto_v0", sq[0], 8'h10);
      chk("auto_v1", sq[1], 8'h20);
      chk("auto_v2", sq[2], 8'h30);
      chk("auto_v3", sq[3], 8'h80);
    end
    chk("auto_ngrants", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("auto_g0", gq[0], 16'h0100);
      chk("auto_g3", gq[3], 16'h0103);
      chk("auto_period1", gt[2] - gt[1], 8);
      chk("auto_period2", gt[3] - gt[2], 8);
    end
    chk("auto_busy_end", busy[1], 1'b0);
    cpu_read(5'd11); chk("auto_rd_ctrl", cpu_dout, 8'h01);
    cpu_write(5'd11, 8'h00, 1);
    cpu_write(5'd10, 8'h00, 1); settle(8);
    chk("auto_marker_addr_kept", pcm_addr, 16'h0104);
    chk("auto_after_snd", snd[15:8], 8'h04);

    // Mid-fetch reload on ch0 with a slow ROM
    cen_all = 1'b1;
    lat = 5;
    cpu_write(5'd0, 8'h40, 1);
    chk("reload_in_service", pcm_cs, 1'b1);
    chk("reload_old_addr", pcm_addr, 16'h1340);
    cpu_write(5'd0, 8'h50, 1);
    saw40 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (snd[7:0] == 8'h40) saw40 = 1'b1;
    end
    chk("reload_stale_dropped", saw40, 1'b0);
    chk("reload_new_addr", pcm_addr, 16'h1350);
    chk("reload_new_snd", snd[7:0], 8'h50);

    // Reset while waiting on the ROM
    cpu_write(5'd0, 8'h60, 1);
    @(negedge clk);
    chk("rstwait_cs_before", pcm_cs, 1'b1);
    #2 rst = 1'b1;
    #1 chk("rstwait_cs_async", pcm_cs, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_addr", pcm_addr, 16'h0000);
    settle(10);
    chk("rstwait_idle", pcm_cs, 1'b0);
    chk("rstwait_snd", snd, 16'h8080);

    // Contention: both channels auto, rate 0, slow ROM
    cpu_write(5'd1, 8'h20, 1);
    cpu_write(5'd0, 8'h00, 1);
    cpu_write(5'd9, 8'h30, 1);
    cpu_write(5'd8, 8'h00, 1);
    settle(20);
    cpu_write(5'd3, 8'h03, 1);
    cpu_write(5'd11, 8'h03, 1);
    settle(10);
    gq.delete(); gt.delete();
    wait_grants(8, "cont_grants_timeout");
    viol = 0;
    for (int i = 1; i < gq.size(); i++)
      if (gq[i][12] == gq[i-1][12] || gq[i] < 16'h2000) viol++;
    chk("cont_alternate", viol, 0);
    chk("cont_busy", busy, 2'b11);
    cpu_write(5'd3, 8'h00, 1);
    cpu_write(5'd11, 8'h00, 1);
    chk("cont_stop", busy, 2'b00);
    settle(20);

`ifdef PCM_LOOP_EN
    // Looping playback on ch1, loop offset 1
    do_reset();
    lat = 2;
    cen_all = 1'b0;
    cpu_write(5'd9, 8'h01, 1);
    cpu_write(5'd8, 8'h00, 1);
    cpu_write(5'd12, 8'h03, 1);
    cpu_write(5'd14, 8'h01, 1);
    cpu_write(5'd15, 8'h00, 1);
    settle(8);
    gq.delete(); gt.delete();
    cpu_write(5'd11, 8'h07, 1);
    wait_grants(8, "loop_grants_timeout");
    viol = 0;
    if (gq.size() >= 8) begin
      if (gq[0] != 16'h0100 || gq[1] != 16'h0101 || gq[2] != 16'h0102 || gq[3] != 16'h0103) viol++;
      if (gq[4] != 16'h0101 || gq[5] != 16'h0102 || gq[6] != 16'h0103 || gq[7] != 16'h0101) viol++;
    end
    chk("loop_sequence", viol, 0);
    chk("loop_busy", busy[1], 1'b1);
    cpu_write(5'd11, 8'h00, 1);
    settle(10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
